sram_dp_bank: RTL

//  Parametrised simple-dual-port SRAM bank: one write port with byte enables, one read port

---
 rtl/sram_pkg.sv | 30 +++
 rtl/sram_dp_array.sv | 53 +++++
 rtl/sram_dp_bank.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared constants and helpers for the simple-dual-port SRAM bank.
package sram_pkg;

   // clear-sweep FSM states
   localparam logic ST_CLEAR = 1'b0;
   localparam logic ST_RUN   = 1'b1;

   // same-address read-during-write behaviour
   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   // widest word the merge helper handles; callers size-cast in and out
   localparam int MERGE_W = 512;

   // Byte-lane merge: bits in lanes with be set come from din, the rest from old.
   function automatic logic [MERGE_W-1:0] f_be_merge(
      input logic [MERGE_W-1:0] old,
      input logic [MERGE_W-1:0] din,
      input logic [MERGE_W-1:0] be,
      input int                 byte_w
   );
      logic [MERGE_W-1:0] res;
      res = old;
      for (int i = 0; i < MERGE_W; i++) begin
         if (be[i / byte_w]) res[i] = din[i];
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_dp_array.sv
// Raw storage: one byte-enabled write port, one registered read port.
// Callers filter out-of-range writes and flag out-of-range reads via rzero.
module sram_dp_array
   import sram_pkg::*;
#(
   parameter  int ADDR_WIDTH = 6,
   parameter  int DATA_WIDTH = 32,
   parameter  int RAM_DEPTH  = 64,
   parameter  int BYTE_WIDTH = 8,
   parameter  int RDW_MODE   = RDW_OLD,
   localparam int NBYTE      = DATA_WIDTH / BYTE_WIDTH
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [NBYTE-1:0]      be,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  re,
   input  logic                  rzero,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
   logic [DATA_WIDTH-1:0] rd_old;
   logic [DATA_WIDTH-1:0] rd_word;

   assign rd_old = mem[raddr];

   // byte-lane write, no reset on the array itself
   always_ff @(posedge clk) begin
      if (we) begin
         for (int k = 0; k < NBYTE; k++) begin
            if (be[k]) mem[waddr][k*BYTE_WIDTH +: BYTE_WIDTH] <= din[k*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   // same-cycle same-address collision: optionally forward the merged write word
   always_comb begin
      rd_word = rd_old;
      if (RDW_MODE == RDW_NEW && we && (waddr == raddr))
         rd_word = DATA_WIDTH'(f_be_merge(MERGE_W'(rd_old), MERGE_W'(din), MERGE_W'(be), BYTE_WIDTH));
   end

   // read register; holds between reads, loads zero for flagged addresses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= rzero ? '0 : rd_word;
   end

endmodule

// File: rtl/sram_dp_bank.sv
// Simple-dual-port SRAM bank: clear-sweep FSM, range check, optional second
// read stage and the valid/err pipeline around sram_dp_array.
module sram_dp_bank
   import sram_pkg::*;
#(
   parameter  int ADDR_WIDTH     = 6,
   parameter  int DATA_WIDTH     = 32,
   parameter  int RAM_DEPTH      = 64,
   parameter  int BYTE_WIDTH     = 8,
   parameter  int RD_LATENCY     = 1,
   parameter  int RDW_MODE       = RDW_OLD,
   parameter  int CLEAR_ON_RESET = 1,
   localparam int NBYTE          = DATA_WIDTH / BYTE_WIDTH
)(
   input  logic                  clk,
   input  logic                  i_rst_n,
   input  logic                  i_clr,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [NBYTE-1:0]      i_be,
   input  logic [DATA_WIDTH-1:0] i_din,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_rvalid,
   output logic                  o_err
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH + 1)'(RAM_DEPTH);
   localparam logic                  ST_RESET  = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

   logic                  state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic                  clr_last;
   logic                  wr_acc, rd_acc, rd_oor;
   logic                  arr_we;
   logic [ADDR_WIDTH-1:0] arr_waddr;
   logic [NBYTE-1:0]      arr_be;
   logic [DATA_WIDTH-1:0] arr_din;
   logic [DATA_WIDTH-1:0] arr_rdata;
   logic [RD_LATENCY:1]   vld_pipe, err_pipe;

   assign clr_last = (cnt_q == LAST_ADDR);
   assign rd_oor   = ({1'b0, i_raddr} >= DEPTH_C);
   assign wr_acc   = i_we && (state_q == ST_RUN) && ({1'b0, i_waddr} < DEPTH_C);
   assign rd_acc   = i_re && (state_q == ST_RUN);

   // state register
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= ST_RESET;
      else          state_q <= state_d;
   end

   // next state: sweep ends after the last address; clr is ignored mid-sweep
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLEAR: if (clr_last) state_d = ST_RUN;
         default:  if (i_clr)    state_d = ST_CLEAR;
      endcase
   end

   // FSM outputs: ready flag and write-port steering (sweep owns the port in CLEAR)
   always_comb begin
      o_ready   = (state_q == ST_RUN);
      arr_we    = wr_acc;
      arr_waddr = i_waddr;
      arr_be    = i_be;
      arr_din   = i_din;
      if (state_q == ST_CLEAR) begin
         arr_we    = 1'b1;
         arr_waddr = cnt_q;
         arr_be    = '1;
         arr_din   = '0;
      end
   end

   // sweep address: advances only while clearing, parked at 0 otherwise
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n)                 cnt_q <= '0;
      else if (state_q == ST_CLEAR) cnt_q <= clr_last ? '0 : cnt_q + 1'b1;
   end

   // valid/err shift register, one bit per read stage
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_pipe <= '0;
         err_pipe <= '0;
      end else begin
         vld_pipe[1] <= rd_acc;
         err_pipe[1] <= rd_acc && rd_oor;
         for (int i = 2; i <= RD_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            err_pipe[i] <= err_pipe[i-1];
         end
      end
   end

   sram_dp_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .RAM_DEPTH  (RAM_DEPTH),
      .BYTE_WIDTH (BYTE_WIDTH),
      .RDW_MODE   (RDW_MODE)
   ) u_array (
      .clk   (clk),
      .rst_n (i_rst_n),
      .we    (arr_we),
      .waddr (arr_waddr),
      .be    (arr_be),
      .din   (arr_din),
      .re    (rd_acc),
      .rzero (rd_oor),
      .raddr (i_raddr),
      .rdata (arr_rdata)
   );

   generate
      if (RD_LATENCY == 2) begin : g_rd2
         logic [DATA_WIDTH-1:0] rdata_q;
         // extra output register, loaded only when stage 1 holds a fresh word
         always_ff @(posedge clk or negedge i_rst_n) begin
            if (!i_rst_n)         rdata_q <= '0;
            else if (vld_pipe[1]) rdata_q <= arr_rdata;
         end
         assign o_rdata = rdata_q;
      end else begin : g_rd1
         assign o_rdata = arr_rdata;
      end
   endgenerate

   assign o_rvalid = vld_pipe[RD_LATENCY];
   assign o_err    = err_pipe[RD_LATENCY];

endmodule
